// File: rtl/pd_pkg.sv
// Shared constants and helpers for the pd_packer width gearbox.
// Holds the default beat width / ratio, the lane counter width rule and
// the lane bit-offset helper used when merging a beat into a wide word.
package pd_pkg;

  localparam int PD_IN_W_DEF  = 8;
  localparam int PD_RATIO_DEF = 4;

  // Lane counter width: enough bits to index RATIO lanes, never zero.
  function automatic int pd_cnt_w(input int ratio);
    return (ratio <= 1) ? 1 : $clog2(ratio);
  endfunction

  // Bit offset of lane `lane` inside a word built from `in_w`-bit beats.
  // Lane 0 sits in the LSBs.
  function automatic int pd_lane_lo(input int lane, input int in_w);
    return lane * in_w;
  endfunction

endpackage

// File: rtl/pd_out_reg.sv
// Valid/ready output holding register (one-entry pipe stage).
// Loads a new word when i_load is high, otherwise holds it until the
// downstream consumer takes it (o_vld && i_rdy), then clears valid.
// The caller only raises i_load when the register is empty or being
// drained in the same cycle, so a held word is never overwritten.
module pd_out_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_load,
  input  logic [W-1:0] i_data,
  input  logic         i_rdy,
  output logic         o_vld,
  output logic [W-1:0] o_data
);

  logic         r_vld;
  logic [W-1:0] r_data;

  // Load / hold / clear of the valid flag and the held word.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its inputs from before the clock edge, independent of order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld  <= 1'b0;
      r_data <= '0;
    end else if (i_load) begin
      r_vld  <= 1'b1;
      r_data <= i_data;
    end else if (r_vld && i_rdy) begin
      r_vld  <= 1'b0;
    end
  end

  assign o_vld  = r_vld;
  assign o_data = r_data;

endmodule

// File: rtl/pd_packer.sv
// pd_packer: packs RATIO consecutive IN_W-bit beats into one OUT_W-bit
// word on a registered valid/ready output. Beat k lands in lane k
// (lane 0 = LSBs). Only the final beat of a word can be back-pressured;
// earlier beats are always accepted into the accumulator.
// Optional build macro PD_PACKER_LAST_EN adds in_plast (early word close,
// unfilled upper lanes zero) and o_pcnt (number of valid lanes).
module pd_packer
  import pd_pkg::*;
#(
  parameter  int IN_W  = PD_IN_W_DEF,
  parameter  int RATIO = PD_RATIO_DEF,
  localparam int OUT_W = IN_W * RATIO,
  localparam int CNT_W = pd_cnt_w(RATIO)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_pvld,
  input  logic [IN_W-1:0]  in_pd,
`ifdef PD_PACKER_LAST_EN
  input  logic             in_plast,
  output logic [CNT_W:0]   o_pcnt,
`endif
  output logic             in_prdy,
  output logic             o_pvld,
  output logic [OUT_W-1:0] o_pd,
  input  logic             o_prdy
);

  logic [CNT_W-1:0] r_cnt;
  logic [OUT_W-1:0] r_acc;

  logic             w_final;
  logic             w_accept;
  logic             w_load;
  logic [OUT_W-1:0] w_merged;

  // A beat closes the word when it fills the top lane (or carries last).
`ifdef PD_PACKER_LAST_EN
  assign w_final = (r_cnt == CNT_W'(RATIO - 1)) || in_plast;
`else
  assign w_final = (r_cnt == CNT_W'(RATIO - 1));
`endif

  // Only a word-closing beat needs room in the output register.
  assign in_prdy  = !w_final || !o_pvld || o_prdy;
  assign w_accept = in_pvld && in_prdy;
  assign w_load   = w_accept && w_final;

  // Accumulator with the incoming beat merged into lane r_cnt.
  // NOTE: the default assignment first keeps this block purely
  // combinational; without it unselected lanes would infer latches.
  always_comb begin
    w_merged = r_acc;
    for (int k = 0; k < RATIO; k++) begin
      if (r_cnt == CNT_W'(k)) begin
        w_merged[pd_lane_lo(k, IN_W) +: IN_W] = in_pd;
      end
    end
  end

  // Lane counter and partial-word accumulator; cleared when a word closes.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
      r_acc <= '0;
    end else if (w_accept) begin
      if (w_final) begin
        r_cnt <= '0;
        r_acc <= '0;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
        r_acc <= w_merged;
      end
    end
  end

`ifdef PD_PACKER_LAST_EN
  logic [CNT_W:0]         w_pcnt_next;
  logic [OUT_W+CNT_W:0]   w_out_data;

  assign w_pcnt_next = (CNT_W + 1)'(r_cnt) + (CNT_W + 1)'(1);

  pd_out_reg #(.W(OUT_W + CNT_W + 1)) u_out_reg (
    .clk    (clk),
    .rst    (rst),
    .i_load (w_load),
    .i_data ({w_pcnt_next, w_merged}),
    .i_rdy  (o_prdy),
    .o_vld  (o_pvld),
    .o_data (w_out_data)
  );

  assign o_pcnt = w_out_data[OUT_W +: CNT_W + 1];
  assign o_pd   = w_out_data[OUT_W-1:0];
`else
  pd_out_reg #(.W(OUT_W)) u_out_reg (
    .clk    (clk),
    .rst    (rst),
    .i_load (w_load),
    .i_data (w_merged),
    .i_rdy  (o_prdy),
    .o_vld  (o_pvld),
    .o_data (o_pd)
  );
`endif

endmodule

// File: tb/tb_pd_packer.sv
// Self-checking bench for pd_packer: a RATIO=4 instance (dut_a) and a
// RATIO=1 instance (dut_b), both IN_W=8. A behavioural model packs the
// accepted beats with shifts and queues and is compared every cycle.
`timescale 1ns/1ps
module tb_pd_packer;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // RATIO=4 instance signals
  logic        a_in_pvld, a_in_prdy, a_in_plast, a_o_pvld, a_o_prdy;
  logic [7:0]  a_in_pd;
  logic [31:0] a_o_pd;
  // RATIO=1 instance signals
  logic        b_in_pvld, b_in_prdy, b_in_plast, b_o_pvld, b_o_prdy;
  logic [7:0]  b_in_pd;
  logic [7:0]  b_o_pd;
`ifdef PD_PACKER_LAST_EN
  logic [2:0]  a_o_pcnt;
  logic [1:0]  b_o_pcnt;
`endif

  pd_packer #(.IN_W(8), .RATIO(4)) dut_a (
    .clk(clk), .rst(rst), .in_pvld(a_in_pvld), .in_pd(a_in_pd),
`ifdef PD_PACKER_LAST_EN
    .in_plast(a_in_plast), .o_pcnt(a_o_pcnt),
`endif
    .in_prdy(a_in_prdy), .o_pvld(a_o_pvld), .o_pd(a_o_pd), .o_prdy(a_o_prdy)
  );

  pd_packer #(.IN_W(8), .RATIO(1)) dut_b (
    .clk(clk), .rst(rst), .in_pvld(b_in_pvld), .in_pd(b_in_pd),
`ifdef PD_PACKER_LAST_EN
    .in_plast(b_in_plast), .o_pcnt(b_o_pcnt),
`endif
    .in_prdy(b_in_prdy), .o_pvld(b_o_pvld), .o_pd(b_o_pd), .o_prdy(b_o_prdy)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  int          pend_n [2];
  logic [31:0] pend_w [2];
  logic [31:0] exp_w0[$], exp_w1[$];
  int          exp_c0[$], exp_c1[$];
  logic [31:0] got0[$], got1[$];
  int          gotc0[$];
  int          gotcyc0[$];
  int          cyc = 0;
  int          a_vld_cyc = 0;
  int          a_stall = 0;
  bit          mon_en = 0;
  bit          rr_a = 0, rr_b = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // One cycle of model bookkeeping for instance id, sampled at negedge.
  task automatic mon(input int id, input int ratio, input logic r,
                     input logic pvld, input logic [7:0] pd, input logic plast,
                     input logic prdy, input logic ovld, input logic [31:0] opd,
                     input int opcnt, input logic ordy);
    int          qn;
    logic [31:0] front;
    int          fcnt;
    bit          exp_rdy;
    string       pfx;
    pfx   = (id == 0) ? "r4" : "r1";
    qn    = (id == 0) ? exp_w0.size() : exp_w1.size();
    front = 32'h0;
    fcnt  = 0;
    if (qn > 0) begin
      front = (id == 0) ? exp_w0[0] : exp_w1[0];
      fcnt  = (id == 0) ? exp_c0[0] : exp_c1[0];
    end
    check({pfx, "_o_pvld"}, ovld, qn > 0);
    if (qn > 0) begin
      check({pfx, "_o_pd"}, opd, front);
`ifdef PD_PACKER_LAST_EN
      check({pfx, "_o_pcnt"}, opcnt, fcnt);
`endif
    end
    // Word-closing beat needs an empty or draining output slot.
    exp_rdy = !((pend_n[id] == ratio - 1) || plast) || (qn == 0) || ordy;
    check({pfx, "_in_prdy"}, prdy, exp_rdy);
    if (r) begin
      pend_n[id] = 0;
      pend_w[id] = 0;
      if (id == 0) begin exp_w0.delete(); exp_c0.delete(); end
      else         begin exp_w1.delete(); exp_c1.delete(); end
      return;
    end
    if (ovld && ordy && qn > 0) begin
      if (id == 0) begin
        void'(exp_w0.pop_front()); void'(exp_c0.pop_front());
        got0.push_back(opd); gotc0.push_back(opcnt); gotcyc0.push_back(cyc);
      end else begin
        void'(exp_w1.pop_front()); void'(exp_c1.pop_front());
        got1.push_back(opd);
      end
    end
    if (pvld && prdy) begin
      pend_w[id] = pend_w[id] | (32'(pd) << (8 * pend_n[id]));
      pend_n[id] = pend_n[id] + 1;
      if (pend_n[id] == ratio || plast) begin
        if (id == 0) begin exp_w0.push_back(pend_w[id]); exp_c0.push_back(pend_n[id]); end
        else         begin exp_w1.push_back(pend_w[id]); exp_c1.push_back(pend_n[id]); end
        pend_n[id] = 0;
        pend_w[id] = 0;
      end
    end
  endtask

  always @(negedge clk) begin
    if (a_in_pvld) assert (!$isunknown(a_in_pd)) else $error("X on a_in_pd while valid");
    if (b_in_pvld) assert (!$isunknown(b_in_pd)) else $error("X on b_in_pd while valid");
    if (mon_en) begin
      if (a_o_pvld === 1'b1) a_vld_cyc++;
      if (a_in_pvld && a_in_prdy !== 1'b1) a_stall++;
`ifdef PD_PACKER_LAST_EN
      mon(0, 4, rst, a_in_pvld, a_in_pd, a_in_plast, a_in_prdy, a_o_pvld, a_o_pd, int'(a_o_pcnt), a_o_prdy);
      mon(1, 1, rst, b_in_pvld, b_in_pd, b_in_plast, b_in_prdy, b_o_pvld, {24'h0, b_o_pd}, int'(b_o_pcnt), b_o_prdy);
`else
      mon(0, 4, rst, a_in_pvld, a_in_pd, 1'b0, a_in_prdy, a_o_pvld, a_o_pd, 0, a_o_prdy);
      mon(1, 1, rst, b_in_pvld, b_in_pd, 1'b0, b_in_prdy, b_o_pvld, {24'h0, b_o_pd}, 0, b_o_prdy);
`endif
    end
  end

  // Random downstream ready when enabled.
  always @(posedge clk) begin
    #1;
    if (rr_a) a_o_prdy = 1'($urandom_range(0, 1));
    if (rr_b) b_o_prdy = 1'($urandom_range(0, 1));
  end

  // ---------------- drivers ----------------
  task automatic drive(input int id, input logic [7:0] d, input logic last, input int gap);
    bit acc;
    int n;
    repeat (gap) begin @(posedge clk); #1; end
    if (id == 0) begin a_in_pvld = 1; a_in_pd = d; a_in_plast = last; end
    else         begin b_in_pvld = 1; b_in_pd = d; b_in_plast = last; end
    acc = 0;
    n   = 0;
    while (!acc && n < 200) begin
      @(negedge clk);
      acc = (id == 0) ? (a_in_prdy === 1'b1) : (b_in_prdy === 1'b1);
      @(posedge clk); #1;
      n++;
    end
    if (!acc) check("drive_timeout", 0, 1);
    if (id == 0) begin a_in_pvld = 0; a_in_plast = 0; end
    else         begin b_in_pvld = 0; b_in_plast = 0; end
  endtask

  task automatic drain(input int id);
    int n;
    n = 0;
    if (id == 0) a_o_prdy = 1; else b_o_prdy = 1;
    while (((id == 0) ? exp_w0.size() : exp_w1.size()) != 0 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 100) check("drain_timeout", 0, 1);
    @(posedge clk); #1;
  endtask

  // ---------------- sequence ----------------
  initial begin
    int n0, v0, s0, c0;
    rst = 1;
    a_in_pvld = 0; a_in_pd = 0; a_in_plast = 0; a_o_prdy = 0;
    b_in_pvld = 0; b_in_pd = 0; b_in_plast = 0; b_o_prdy = 0;
    @(posedge clk); #1;
    mon_en = 1;
    repeat (2) begin @(posedge clk); #1; end
    rst = 0;

    // Reset state
    @(negedge clk);
    check("rst_a_o_pvld", a_o_pvld, 0);
    check("rst_a_o_pd", a_o_pd, 0);
    check("rst_a_in_prdy", a_in_prdy, 1);
    check("rst_b_o_pvld", b_o_pvld, 0);
    check("rst_b_in_prdy", b_in_prdy, 1);
`ifdef PD_PACKER_LAST_EN
    check("rst_a_o_pcnt", a_o_pcnt, 0);
`endif
    @(posedge clk); #1;

    // T1: back-to-back word, single-cycle valid pulse
    a_o_prdy = 1;
    v0 = a_vld_cyc; n0 = got0.size();
    drive(0, 8'h11, 0, 0); drive(0, 8'h22, 0, 0);
    drive(0, 8'h33, 0, 0); drive(0, 8'h44, 0, 0);
    repeat (3) begin @(posedge clk); #1; end
    check("t1_words", got0.size() - n0, 1);
    check("t1_word", got0[$], 32'h44332211);
    check("t1_vld_cycles", a_vld_cyc - v0, 1);

    // T2: stalled output, second word's final beat back-pressured
    a_o_prdy = 0;
    n0 = got0.size();
    for (int i = 1; i <= 7; i++) drive(0, 8'(i), 0, 0);
    a_in_pvld = 1; a_in_pd = 8'h08;
    repeat (3) begin
      @(negedge clk);
      check("t2_stall_prdy", a_in_prdy, 0);
    end
    @(posedge clk); #1;
    a_o_prdy = 1;
    drive(0, 8'h08, 0, 0);
    drain(0);
    check("t2_words", got0.size() - n0, 2);
    check("t2_word0", got0[n0], 32'h04030201);
    check("t2_word1", got0[n0 + 1], 32'h08070605);

    // T3: continuous stream, 40 beats -> 10 words at one per 4 cycles
    a_o_prdy = 1;
    s0 = a_stall; n0 = got0.size(); c0 = gotcyc0.size();
    for (int i = 0; i < 40; i++) drive(0, 8'(8'hA0 + i), 0, 0);
    drain(0);
    check("t3_no_stall", a_stall - s0, 0);
    check("t3_words", got0.size() - n0, 10);
    for (int j = c0 + 1; j < gotcyc0.size(); j++)
      check("t3_cadence", gotcyc0[j] - gotcyc0[j - 1], 4);

    // T4: reset mid-word discards the partial word
    n0 = got0.size();
    drive(0, 8'hAA, 0, 0); drive(0, 8'hBB, 0, 0);
    rst = 1;
    @(negedge clk);
    check("t4_vld_in_rst", a_o_pvld, 0);
    @(posedge clk); #1;
    rst = 0;
    @(negedge clk);
    check("t4_vld_after_rst", a_o_pvld, 0);
    check("t4_pd_after_rst", a_o_pd, 0);
    @(posedge clk); #1;
    for (int i = 1; i <= 4; i++) drive(0, 8'(i), 0, 0);
    drain(0);
    check("t4_words", got0.size() - n0, 1);
    check("t4_word", got0[$], 32'h04030201);

    // T5: random gaps and random ready, RATIO=4
    n0 = got0.size();
    rr_a = 1;
    for (int i = 0; i < 200; i++) drive(0, 8'($urandom), 0, $urandom_range(0, 2));
    rr_a = 0;
    drain(0);
    check("t5_words", got0.size() - n0, 50);

    // T6: RATIO=1 register slice, random ready
    n0 = got1.size();
    rr_b = 1;
    for (int i = 0; i < 200; i++) drive(1, 8'($urandom), 0, $urandom_range(0, 1));
    rr_b = 0;
    drain(1);
    check("t6_words", got1.size() - n0, 200);

`ifdef PD_PACKER_LAST_EN
    // T7: early close with in_plast, then a full word from lane 0
    a_o_prdy = 1;
    n0 = got0.size();
    drive(0, 8'h5A, 0, 0); drive(0, 8'h6B, 1, 0);
    for (int i = 1; i <= 4; i++) drive(0, 8'(i), 0, 0);
    drain(0);
    check("t7_words", got0.size() - n0, 2);
    check("t7_word0", got0[n0], 32'h00006B5A);
    check("t7_pcnt0", gotc0[n0], 2);
    check("t7_word1", got0[n0 + 1], 32'h04030201);
    check("t7_pcnt1", gotc0[n0 + 1], 4);
`endif

    repeat (2) begin @(posedge clk); #1; end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
